// File: rtl/ddr4_v2_2_20_wrap_index_gen.sv
// Wrapping word-index sequencer: expands one {start, mask, len} command into len+1 index beats.
// Optional back-to-back command acceptance on the final beat: define DDR4_WRAP_INDEX_GEN_B2B_EN.
module ddr4_v2_2_20_wrap_index_gen #(
    parameter           C_FAMILY     = "virtex6",
    parameter int       C_DATA_WIDTH = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic [C_DATA_WIDTH-1:0] CMD_START,
    input  logic [C_DATA_WIDTH-1:0] CMD_MASK,
    input  logic [7:0]              CMD_LEN,
    output logic                    IDX_VALID,
    input  logic                    IDX_READY,
    output logic [C_DATA_WIDTH-1:0] IDX,
    output logic                    IDX_FIRST,
    output logic                    IDX_LAST,
    output logic                    IDX_WRAP,
    output logic                    BUSY,
    output logic                    dbg_state
);

    localparam int W = C_DATA_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [W-1:0]   mask_q, mask_d;
    logic [7:0]     len_q, len_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           first_q, first_d;
    logic           last_q, last_d;
    logic           wrap_q, wrap_d;

    logic [W-1:0]   idx_next;
    logic [7:0]     cnt_next;
    logic           cmd_ready;
    logic           cmd_accept;
    logic           beat_done;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload never depend on ready, and hold until the transfer happens.
    assign cmd_accept = CMD_VALID && cmd_ready;
    assign beat_done  = (state_q == ST_RUN) && IDX_READY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            last_q  <= last_d;
            wrap_q  <= wrap_d;
        end
    end

    // Masked bits count up with the carry confined to them; unmasked bits are frozen.
    always_comb begin
        idx_next = (idx_q & ~mask_q) | ((idx_q + W'(1)) & mask_q);
        cnt_next = cnt_q + 8'd1;

        state_d  = state_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        last_d   = last_q;
        wrap_d   = wrap_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_d = ST_RUN;
                    idx_d   = CMD_START;
                    mask_d  = CMD_MASK;
                    len_d   = CMD_LEN;
                    cnt_d   = 8'd0;
                    first_d = 1'b1;
                    last_d  = (CMD_LEN == 8'd0);
                    wrap_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (beat_done) begin
                    if (last_q) begin
                        // cmd_accept can only be high here in the back-to-back build.
                        if (cmd_accept) begin
                            idx_d   = CMD_START;
                            mask_d  = CMD_MASK;
                            len_d   = CMD_LEN;
                            cnt_d   = 8'd0;
                            first_d = 1'b1;
                            last_d  = (CMD_LEN == 8'd0);
                            wrap_d  = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            first_d = 1'b0;
                            last_d  = 1'b0;
                            wrap_d  = 1'b0;
                        end
                    end else begin
                        idx_d   = idx_next;
                        cnt_d   = cnt_next;
                        first_d = 1'b0;
                        last_d  = (cnt_next == len_q);
                        wrap_d  = ((idx_next & mask_q) == '0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
`ifdef DDR4_WRAP_INDEX_GEN_B2B_EN
        cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_RUN) && last_q && IDX_READY);
`else
        cmd_ready = (state_q == ST_IDLE);
`endif
        CMD_READY = cmd_ready;
        IDX_VALID = (state_q == ST_RUN);
        BUSY      = (state_q == ST_RUN);
        IDX       = idx_q;
        IDX_FIRST = first_q;
        IDX_LAST  = last_q;
        IDX_WRAP  = wrap_q;
        dbg_state = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_ddr4_v2_2_20_wrap_index_gen.sv
// Bench for the wrapping index sequencer: directed vector table, stall/reset/back-to-back
// sequences, and randomized commands scored against a rule-level model.
module tb_ddr4_v2_2_20_wrap_index_gen;

    localparam int W  = 4;
    localparam int BW = W + 3;

    logic          ACLK;
    logic          ARESET;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [W-1:0]  CMD_START;
    logic [W-1:0]  CMD_MASK;
    logic [7:0]    CMD_LEN;
    logic          IDX_VALID;
    logic          IDX_READY;
    logic [W-1:0]  IDX;
    logic          IDX_FIRST;
    logic          IDX_LAST;
    logic          IDX_WRAP;
    logic          BUSY;
    logic          dbg_state;

    ddr4_v2_2_20_wrap_index_gen #(
        .C_FAMILY     ("virtex6"),
        .C_DATA_WIDTH (W)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_START (CMD_START),
        .CMD_MASK  (CMD_MASK),
        .CMD_LEN   (CMD_LEN),
        .IDX_VALID (IDX_VALID),
        .IDX_READY (IDX_READY),
        .IDX       (IDX),
        .IDX_FIRST (IDX_FIRST),
        .IDX_LAST  (IDX_LAST),
        .IDX_WRAP  (IDX_WRAP),
        .BUSY      (BUSY),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // Beat record: {idx, first, last, wrap}
    logic [BW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          rnd_ready = 1'b0;
    logic          hold_pending = 1'b0;
    logic [BW-1:0] held;

    typedef struct {
        logic [3:0]        start;
        logic [3:0]        mask;
        logic [7:0]        len;
        int                n;
        logic [7:0][BW-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [BW-1:0] bt(input logic [3:0] i, input logic f, input logic l, input logic w);
        return {i, f, l, w};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: apply the index rule beat by beat from the command fields.
    task automatic model_push(input logic [3:0] s, input logic [3:0] m, input logic [7:0] l);
        int cur;
        int mi;
        cur = int'(s);
        mi  = int'(m);
        for (int b = 0; b <= int'(l); b++) begin
            exp_q.push_back({4'(cur), (b == 0), (b == int'(l)), ((b != 0) && ((cur & mi) == 0))});
            cur = ((cur & (15 - mi)) | ((cur + 1) & mi)) % 16;
        end
    endtask

    task automatic check_cycle();
        logic [BW-1:0] act;
        logic [BW-1:0] e;
        act = {IDX, IDX_FIRST, IDX_LAST, IDX_WRAP};
        if (ARESET) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) chk("hold_stable", 32'(act), 32'(held));
            if (IDX_VALID && IDX_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no beat", act);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'(act), 32'(e));
                end
            end
            hold_pending = IDX_VALID && !IDX_READY;
            held = act;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        check_cycle();
        @(posedge ACLK);
        @(negedge ACLK);
        if (rnd_ready) IDX_READY = 1'($urandom_range(0, 1));
    endtask

    task automatic send_cmd(input logic [3:0] s, input logic [3:0] m, input logic [7:0] l, input bit use_model);
        bit ok;
        ok = 1'b0;
        CMD_START = s;
        CMD_MASK  = m;
        CMD_LEN   = l;
        CMD_VALID = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (CMD_READY) begin
                ok = 1'b1;
                if (use_model) model_push(s, m, l);
            end
            step();
        end
        CMD_VALID = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout: got no accept expected accept");
        end else begin
            chk("first_beat_latency", {30'd0, IDX_VALID, IDX_FIRST}, 32'd3);
        end
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000 && (IDX_VALID || exp_q.size() != 0); i++) step();
        if (i == 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        chk("post_idx_valid", 32'(IDX_VALID), 32'd0);
        chk("post_busy", 32'(BUSY), 32'd0);
        chk("post_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("post_leftover", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [5:0] hist;
        logic [5:0] hist_exp;
        bit         take;

        vecs[0].start = 4'h5; vecs[0].mask = 4'h3; vecs[0].len = 8'd3; vecs[0].n = 4;
        vecs[0].exp[0] = bt(4'h5, 1, 0, 0); vecs[0].exp[1] = bt(4'h6, 0, 0, 0);
        vecs[0].exp[2] = bt(4'h7, 0, 0, 0); vecs[0].exp[3] = bt(4'h4, 0, 1, 1);

        vecs[1].start = 4'hE; vecs[1].mask = 4'hF; vecs[1].len = 8'd5; vecs[1].n = 6;
        vecs[1].exp[0] = bt(4'hE, 1, 0, 0); vecs[1].exp[1] = bt(4'hF, 0, 0, 0);
        vecs[1].exp[2] = bt(4'h0, 0, 0, 1); vecs[1].exp[3] = bt(4'h1, 0, 0, 0);
        vecs[1].exp[4] = bt(4'h2, 0, 0, 0); vecs[1].exp[5] = bt(4'h3, 0, 1, 0);

        vecs[2].start = 4'h9; vecs[2].mask = 4'h1; vecs[2].len = 8'd4; vecs[2].n = 5;
        vecs[2].exp[0] = bt(4'h9, 1, 0, 0); vecs[2].exp[1] = bt(4'h8, 0, 0, 1);
        vecs[2].exp[2] = bt(4'h9, 0, 0, 0); vecs[2].exp[3] = bt(4'h8, 0, 0, 1);
        vecs[2].exp[4] = bt(4'h9, 0, 1, 0);

        vecs[3].start = 4'hA; vecs[3].mask = 4'h3; vecs[3].len = 8'd0; vecs[3].n = 1;
        vecs[3].exp[0] = bt(4'hA, 1, 1, 0);

        // Zero mask: index frozen, every non-first beat counts as a wrap.
        vecs[4].start = 4'h6; vecs[4].mask = 4'h0; vecs[4].len = 8'd2; vecs[4].n = 3;
        vecs[4].exp[0] = bt(4'h6, 1, 0, 0); vecs[4].exp[1] = bt(4'h6, 0, 0, 1);
        vecs[4].exp[2] = bt(4'h6, 0, 1, 1);

        // Reset with a command pending: it must be ignored.
        ARESET    = 1'b1;
        CMD_VALID = 1'b1;
        CMD_START = 4'h7;
        CMD_MASK  = 4'hF;
        CMD_LEN   = 8'd3;
        IDX_READY = 1'b1;
        @(negedge ACLK);
        repeat (3) step();
        chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("rst_idx_valid", 32'(IDX_VALID), 32'd0);
        chk("rst_idx", 32'(IDX), 32'd0);
        chk("rst_flags", {29'd0, IDX_FIRST, IDX_LAST, IDX_WRAP}, 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        ARESET    = 1'b0;
        CMD_VALID = 1'b0;
        step();
        chk("no_beat_after_rst", 32'(IDX_VALID), 32'd0);

        // Directed table.
        for (int v = 0; v < 5; v++) begin
            IDX_READY = 1'b1;
            for (int b = 0; b < vecs[v].n; b++) exp_q.push_back(vecs[v].exp[b]);
            send_cmd(vecs[v].start, vecs[v].mask, vecs[v].len, 1'b0);
            drain();
        end

        // Stall on beat 2: index 6 must hold, then 7,4 follow.
        IDX_READY = 1'b1;
        send_cmd(4'h5, 4'h3, 8'd3, 1'b1);
        step();
        IDX_READY = 1'b0;
        repeat (3) begin
            step();
            chk("stall_idx", {24'd0, IDX, IDX_FIRST, IDX_LAST, IDX_WRAP, IDX_VALID}, {24'd0, 4'h6, 3'b000, 1'b1});
        end
        IDX_READY = 1'b1;
        drain();

        // Reset mid-burst after two beats.
        send_cmd(4'h5, 4'h3, 8'd3, 1'b1);
        step();
        step();
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        exp_q.delete();
        chk("midrst_idx_valid", 32'(IDX_VALID), 32'd0);
        chk("midrst_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        chk("midrst_idx", 32'(IDX), 32'd0);
        repeat (3) begin
            step();
            chk("midrst_no_beats", 32'(IDX_VALID), 32'd0);
        end

        // Two queued commands: gap between bursts depends on the build.
        IDX_READY = 1'b1;
        send_cmd(4'h5, 4'h3, 8'd1, 1'b1);
        CMD_START = 4'h9;
        CMD_MASK  = 4'h1;
        CMD_LEN   = 8'd1;
        CMD_VALID = 1'b1;
        hist = '0;
        for (int c = 0; c < 6; c++) begin
            hist[5 - c] = IDX_VALID;
            take = CMD_VALID && CMD_READY;
            if (take) model_push(4'h9, 4'h1, 8'd1);
            step();
            if (take) CMD_VALID = 1'b0;
        end
`ifdef DDR4_WRAP_INDEX_GEN_B2B_EN
        hist_exp = 6'b111100;
`else
        hist_exp = 6'b110110;
`endif
        chk("b2b_valid_pattern", 32'(hist), 32'(hist_exp));
        chk("b2b_second_accepted", 32'(CMD_VALID), 32'd0);
        CMD_VALID = 1'b0;
        drain();

        // Randomized commands with random downstream back-pressure.
        rnd_ready = 1'b1;
        for (int r = 0; r < 40; r++) begin
            logic [3:0] s;
            logic [3:0] m;
            logic [7:0] l;
            s = 4'($urandom_range(0, 15));
            m = 4'($urandom_range(0, 15));
            l = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
            send_cmd(s, m, l, 1'b1);
            drain();
        end
        rnd_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
